// File: rtl/bin_to_bcd4.sv
// bin_to_bcd4: sequential double-dabble converter from an unsigned binary
// readout to four BCD digits for the seven-segment driver. One input bit is
// consumed per clock; the digit outputs hold the previous result until a new
// conversion finishes, so the display never shows a partial value.
//
// Handshake: a value is accepted at a rising clk_50mhz edge where
// in_valid & in_ready are both high. in_ready is high only in IDLE, and
// in_valid is ignored (not queued) at any other time. done pulses for one
// cycle in the cycle the new bcd1..bcd4/ovf values first appear.
module bin_to_bcd4 #(
    parameter int          IN_WIDTH  = 14,
    parameter logic [3:0]  OVF_DIGIT = 4'hE
) (
    input  logic                clk_50mhz,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] bin,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [3:0]          bcd1,
    output logic [3:0]          bcd2,
    output logic [3:0]          bcd3,
    output logic [3:0]          bcd4,
    output logic                ovf,
    output logic                done,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int                  CNT_W   = $clog2(IN_WIDTH + 1);
    localparam logic [IN_WIDTH-1:0] MAX_VAL = IN_WIDTH'(9999);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [IN_WIDTH-1:0] shift_reg;
    logic [15:0]         scratch;
    logic [15:0]         scratch_adj;
    logic [15:0]         scratch_shifted;
    logic                shifted_out_unused;
    logic                ovf_pend;
    logic                accept;
    logic                last_shift;

    assign accept     = in_valid & in_ready;
    assign last_shift = (bit_cnt == CNT_W'(1));
    assign dbg_state  = state;

    // Add-3 correction: every BCD nibble of 5 or more gets +3 before the shift.
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 4; i++) begin
            if (scratch[i*4 +: 4] >= 4'd5) begin
                scratch_adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    // The bit pushed out above scratch[15] only carries information for
    // values > 9999, which are replaced by OVF_DIGIT anyway, so it is dropped.
    assign {shifted_out_unused, scratch_shifted} = {scratch_adj, shift_reg[IN_WIDTH-1]};

    // State register.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift-and-add while busy, publish in LOAD.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            scratch   <= '0;
            ovf_pend  <= 1'b0;
            bcd1      <= 4'd0;
            bcd2      <= 4'd0;
            bcd3      <= 4'd0;
            bcd4      <= 4'd0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= bin;
                        scratch   <= '0;
                        bit_cnt   <= CNT_W'(IN_WIDTH);
                        ovf_pend  <= (bin > MAX_VAL);
                    end
                end
                SHIFT: begin
                    scratch   <= scratch_shifted;
                    shift_reg <= {shift_reg[IN_WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt - CNT_W'(1);
                end
                LOAD: begin
                    if (ovf_pend) begin
                        bcd1 <= OVF_DIGIT;
                        bcd2 <= OVF_DIGIT;
                        bcd3 <= OVF_DIGIT;
                        bcd4 <= OVF_DIGIT;
                    end else begin
                        bcd1 <= scratch[3:0];
                        bcd2 <= scratch[7:4];
                        bcd3 <= scratch[11:8];
                        bcd4 <= scratch[15:12];
                    end
                    ovf  <= ovf_pend;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd4.sv
// Directed bench for bin_to_bcd4 (IN_WIDTH=14). Inputs change on the falling
// edge, outputs are sampled on the falling edge.
module tb_bin_to_bcd4;

    localparam int W = 14;

    logic         clk_50mhz;
    logic         reset;
    logic [W-1:0] bin;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   bcd1, bcd2, bcd3, bcd4;
    logic         ovf;
    logic         done;
    logic [1:0]   dbg_state;

    int n_vec = 0;
    int n_err = 0;

    bin_to_bcd4 #(.IN_WIDTH(W), .OVF_DIGIT(4'hE)) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bcd4      (bcd4),
        .ovf       (ovf),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock: 50 MHz.
    initial clk_50mhz = 1'b0;
    always #10 clk_50mhz = ~clk_50mhz;

    function automatic logic [16:0] packed_out();
        return {ovf, bcd4, bcd3, bcd2, bcd1};
    endfunction

    // Reference: {ovf, thousands, hundreds, tens, ones} via integer division.
    function automatic logic [16:0] ref_model(int v);
        if (v > 9999) return {1'b1, 16'hEEEE};
        return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done, counting falling edges; bounded so a stuck DUT still ends.
    // stable reports whether outputs held prev_out on every edge before done.
    task automatic wait_done(input logic [16:0] prev_out, output int cyc, output bit stable,
                             output int n_busy_ready);
        cyc = 0;
        stable = 1'b1;
        n_busy_ready = 0;
        do begin
            @(negedge clk_50mhz);
            cyc++;
            if (!done && packed_out() !== prev_out) stable = 1'b0;
            if (!done && in_ready) n_busy_ready++;
        end while (!done && cyc < 40);
    endtask

    // One isolated conversion: handshake, latency, result, stability, done width.
    task automatic convert(input int v, input string tag);
        logic [16:0] prev;
        int cyc, nbr;
        bit stable;
        prev = packed_out();
        bin = W'(v);
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        in_valid = 1'b0;
        wait_done(prev, cyc, stable, nbr);
        check({tag, "_latency"}, 32'(cyc), 32'd15);
        check({tag, "_result"}, 32'(packed_out()), 32'(ref_model(v)));
        check({tag, "_stable"}, 32'(stable), 32'd1);
        check({tag, "_busy_ready"}, 32'(nbr), 32'd0);
        @(negedge clk_50mhz);
        check({tag, "_done_width"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [16:0] prev;
        int cyc, nbr, n_done;
        bit stable;

        // Reset block.
        reset = 1'b1;
        in_valid = 1'b0;
        bin = '0;
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        reset = 1'b0;
        check("reset_out", 32'(packed_out()), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        check("reset_state", 32'(dbg_state), 32'd0);

        // 1: basic conversion.
        convert(1234, "t1_1234");

        // 2: back-to-back with in_valid held; second accept in the done cycle.
        prev = packed_out();
        bin = W'(0);
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        check("t2_busy_ready", 32'(in_ready), 32'd0);
        bin = W'(9999);
        wait_done(prev, cyc, stable, nbr);
        check("t2_first_latency", 32'(cyc), 32'd15);
        check("t2_first_result", 32'(packed_out()), 32'(ref_model(0)));
        check("t2_ready_in_done", 32'(in_ready), 32'd1);
        prev = packed_out();
        wait_done(prev, cyc, stable, nbr);
        in_valid = 1'b0;
        check("t2_second_spacing", 32'(cyc), 32'd16);
        check("t2_second_result", 32'(packed_out()), 32'(ref_model(9999)));
        check("t2_second_stable", 32'(stable), 32'd1);
        @(negedge clk_50mhz);
        check("t2_done_width", 32'(done), 32'd0);

        // 3: overflow boundaries, then recovery to a normal value.
        convert(10000, "t3_10000");
        convert(16383, "t3_16383");
        convert(42, "t3_42");

        // 4: in_valid during SHIFT is ignored; 1111 taken only back in IDLE.
        prev = packed_out();
        bin = W'(5678);
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        bin = W'(1111);
        check("t4_busy_ready", 32'(in_ready), 32'd0);
        wait_done(prev, cyc, stable, nbr);
        check("t4_first_latency", 32'(cyc), 32'd15);
        check("t4_first_result", 32'(packed_out()), 32'(ref_model(5678)));
        check("t4_no_busy_accept", 32'(nbr), 32'd0);
        prev = packed_out();
        wait_done(prev, cyc, stable, nbr);
        in_valid = 1'b0;
        check("t4_second_spacing", 32'(cyc), 32'd16);
        check("t4_second_result", 32'(packed_out()), 32'(ref_model(1111)));
        @(negedge clk_50mhz);

        // 5: reset in SHIFT cycle 7 aborts the conversion.
        bin = W'(4321);
        in_valid = 1'b1;
        @(negedge clk_50mhz);
        in_valid = 1'b0;
        repeat (6) @(negedge clk_50mhz);
        check("t5_in_shift", 32'(dbg_state), 32'd1);
        reset = 1'b1;
        @(negedge clk_50mhz);
        reset = 1'b0;
        check("t5_out_cleared", 32'(packed_out()), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_ready", 32'(in_ready), 32'd1);
        n_done = 0;
        repeat (20) begin
            @(negedge clk_50mhz);
            if (done) n_done++;
        end
        check("t5_no_stale_done", 32'(n_done), 32'd0);

        // Reset and handshake in the same cycle: reset wins.
        bin = W'(77);
        in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clk_50mhz);
        reset = 1'b0;
        in_valid = 1'b0;
        check("rst_hs_state", 32'(dbg_state), 32'd0);
        n_done = 0;
        repeat (20) begin
            @(negedge clk_50mhz);
            if (done) n_done++;
        end
        check("rst_hs_no_done", 32'(n_done), 32'd0);
        check("rst_hs_out", 32'(packed_out()), 32'd0);

        // 6: random sweep over the full input range.
        for (int i = 0; i < 40; i++) begin
            convert(int'($urandom_range(0, 16383)), "t6_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
